// File: rtl/iq_remodulator_if.sv
// I/Q input stream and RF output stream of the IQ re-modulator.
// slave: the re-modulator's view of the bus. master: the source/sink view.
interface iq_remodulator_if #(
    parameter int unsigned Data_bits = 10
);
    logic signed [Data_bits-1:0] I_data_in;
    logic signed [Data_bits-1:0] Q_data_in;
    logic                        iq_valid_i;
    logic                        iq_last_i;
    logic                        iq_ready_o;
    logic                        phase_sync_i;
    logic signed [Data_bits-1:0] rf_data_o;
    logic                        rf_valid_o;
    logic                        rf_last_o;
    logic                        rf_ready_i;

    modport slave (
        input  I_data_in, Q_data_in, iq_valid_i, iq_last_i, phase_sync_i, rf_ready_i,
        output iq_ready_o, rf_data_o, rf_valid_o, rf_last_o
    );

    modport master (
        output I_data_in, Q_data_in, iq_valid_i, iq_last_i, phase_sync_i, rf_ready_i,
        input  iq_ready_o, rf_data_o, rf_valid_o, rf_last_o
    );
endinterface

// File: rtl/iq_remodulator.sv
// Re-modulates baseband I/Q pairs to real RF at fs = 4*fc: rf = I*cos[k] + Q*sin[k].
// Define REMOD_SATURATE_EN to saturate the output (and add sat_flag_o) instead of wrapping.
module iq_remodulator #(
    parameter real         Freq_carrier  = 5e6,
    parameter real         Freq_sampling = 20e6,
    parameter int unsigned Data_bits     = 10,
    parameter int unsigned Coeff_bits    = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef REMOD_SATURATE_EN
    output logic sat_flag_o,
`endif
    iq_remodulator_if.slave bus
);

    localparam int unsigned PROD_W = Data_bits + Coeff_bits;
    localparam int unsigned SUM_W  = PROD_W + 1;

    localparam logic signed [Coeff_bits-1:0] C_MAX = {1'b0, {(Coeff_bits-1){1'b1}}};
    localparam logic signed [Coeff_bits-1:0] C_MIN = {1'b1, {(Coeff_bits-1){1'b0}}};

    if (Freq_sampling != 4.0 * Freq_carrier) begin : g_bad_ratio
        $error("iq_remodulator: only Freq_sampling/Freq_carrier = 4 is supported");
    end

    logic [1:0]                   phase_q;
    logic [1:0]                   eff_phase_c;
    logic signed [Coeff_bits-1:0] cos_c;
    logic signed [Coeff_bits-1:0] sin_c;
    logic signed [PROD_W-1:0]     p_i_c;
    logic signed [PROD_W-1:0]     p_q_c;
    logic signed [PROD_W-1:0]     p_i_q;
    logic signed [PROD_W-1:0]     p_q_q;
    logic                         s1_valid_q;
    logic                         s1_last_q;
    logic signed [SUM_W-1:0]      sum_c;
    logic signed [Data_bits-1:0]  rf_next_c;
    logic                         accept_c;
    logic                         s2_free_c;
    logic                         s1_adv_c;

    // Handshake and pipeline flow control
    assign s2_free_c      = !bus.rf_valid_o || bus.rf_ready_i;
    assign s1_adv_c       = s1_valid_q && s2_free_c;
    assign bus.iq_ready_o = !s1_valid_q || s2_free_c;
    assign accept_c       = bus.iq_valid_i && bus.iq_ready_o;

    // Coefficient lookup at the effective phase, then the two products
    always_comb begin
        eff_phase_c = bus.phase_sync_i ? 2'd0 : phase_q;
        cos_c       = '0;
        sin_c       = '0;
        case (eff_phase_c)
            2'd0: cos_c = C_MAX;
            2'd1: sin_c = C_MIN;
            2'd2: cos_c = C_MIN;
            2'd3: sin_c = C_MAX;
            default: ;
        endcase
        p_i_c = PROD_W'(bus.I_data_in) * PROD_W'(cos_c);
        p_q_c = PROD_W'(bus.Q_data_in) * PROD_W'(sin_c);
    end

    assign sum_c = SUM_W'(p_i_q) + SUM_W'(p_q_q);

`ifdef REMOD_SATURATE_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (Data_bits - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [SUM_W-1:0] shifted_c;
    logic                    clamp_c;

    always_comb begin
        shifted_c = sum_c >>> (Coeff_bits - 1);
        clamp_c   = 1'b0;
        rf_next_c = Data_bits'(shifted_c);
        if (shifted_c > SAT_MAX) begin
            rf_next_c = Data_bits'(SAT_MAX);
            clamp_c   = 1'b1;
        end else if (shifted_c < SAT_MIN) begin
            rf_next_c = Data_bits'(SAT_MIN);
            clamp_c   = 1'b1;
        end
    end

    // Sticky: only a reset clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_flag_o <= 1'b0;
        end else if (s1_adv_c && clamp_c) begin
            sat_flag_o <= 1'b1;
        end
    end
`else
    assign rf_next_c = Data_bits'(sum_c >>> (Coeff_bits - 1));
`endif

    // Phase counter: advances only on accepted pairs, restarts after a line end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 2'd0;
        end else if (accept_c) begin
            phase_q <= bus.iq_last_i ? 2'd0 : eff_phase_c + 2'd1;
        end else if (bus.phase_sync_i) begin
            phase_q <= 2'd0;
        end
    end

    // Stage 1: products
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            p_i_q      <= '0;
            p_q_q      <= '0;
        end else if (accept_c) begin
            s1_valid_q <= 1'b1;
            s1_last_q  <= bus.iq_last_i;
            p_i_q      <= p_i_c;
            p_q_q      <= p_q_c;
        end else if (s1_adv_c) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: sum, scale, reduce; data holds while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rf_valid_o <= 1'b0;
            bus.rf_last_o  <= 1'b0;
            bus.rf_data_o  <= '0;
        end else if (s1_adv_c) begin
            bus.rf_valid_o <= 1'b1;
            bus.rf_last_o  <= s1_last_q;
            bus.rf_data_o  <= rf_next_c;
        end else if (s2_free_c) begin
            bus.rf_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iq_remodulator.sv
// Directed-vector bench for iq_remodulator; expected RF values are hand-computed.
module tb_iq_remodulator;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic signed [9:0] rx_data[$];
    logic              rx_last[$];

    iq_remodulator_if #(.Data_bits(10)) bus ();

`ifdef REMOD_SATURATE_EN
    logic sat_flag_o;
`endif

    iq_remodulator #(
        .Freq_carrier (5e6),
        .Freq_sampling(20e6),
        .Data_bits    (10),
        .Coeff_bits   (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
`ifdef REMOD_SATURATE_EN
        .sat_flag_o(sat_flag_o),
`endif
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    // Record every completed output transfer
    always @(negedge clk_i) begin
        if (rst_ni && bus.rf_valid_o && bus.rf_ready_i) begin
            rx_data.push_back(bus.rf_data_o);
            rx_last.push_back(bus.rf_last_o);
        end
    end

    task automatic idle(input int n);
        bus.iq_valid_i   = 1'b0;
        bus.iq_last_i    = 1'b0;
        bus.phase_sync_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Present one pair and hold it until accepted (bounded)
    task automatic send(input int i_v, input int q_v, input logic last_v, input logic sync_v);
        int   n;
        logic rdy;
        bus.I_data_in    = 10'(i_v);
        bus.Q_data_in    = 10'(q_v);
        bus.iq_last_i    = last_v;
        bus.phase_sync_i = sync_v;
        bus.iq_valid_i   = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk_i);
            rdy = bus.iq_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: pair I=%0d Q=%0d not accepted in 50 cycles", i_v, q_v);
        end
    endtask

    task automatic test_reset();
        bus.I_data_in = '0; bus.Q_data_in = '0;
        bus.iq_valid_i = 1'b0; bus.iq_last_i = 1'b0;
        bus.phase_sync_i = 1'b0; bus.rf_ready_i = 1'b1;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if (bus.rf_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b want 0", bus.rf_valid_o);
        end
        vectors++;
        if (bus.rf_data_o !== 10'sd0) begin
            miscompares++; $display("FAIL reset_data: got %0d want 0", bus.rf_data_o);
        end
        vectors++;
        if (bus.rf_last_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_last: got %b want 0", bus.rf_last_o);
        end
`ifdef REMOD_SATURATE_EN
        vectors++;
        if (sat_flag_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag_o);
        end
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        vectors++;
        if (bus.iq_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b want 1", bus.iq_ready_o);
        end
    endtask

    task automatic test_cos();
        int exp_d[4] = '{99, 0, -100, 0};
        rx_data.delete(); rx_last.delete();
        bus.rf_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.I_data_in = 10'sd100; bus.Q_data_in = 10'sd0;
            bus.iq_last_i = 1'b0; bus.phase_sync_i = 1'b0; bus.iq_valid_i = 1'b1;
            if (i == 0) begin
                vectors++;
                if (bus.iq_ready_o !== 1'b1) begin
                    miscompares++; $display("FAIL cos_ready: got %b want 1", bus.iq_ready_o);
                end
            end
            @(posedge clk_i);
            #1;
            if (i == 0) begin
                vectors++;
                if (bus.rf_valid_o !== 1'b0) begin
                    miscompares++; $display("FAIL cos_latency1: rf_valid got %b want 0", bus.rf_valid_o);
                end
            end
            if (i == 1) begin
                vectors++;
                if (bus.rf_valid_o !== 1'b1 || bus.rf_data_o !== 10'sd99) begin
                    miscompares++;
                    $display("FAIL cos_latency2: valid=%b data=%0d want valid=1 data=99",
                             bus.rf_valid_o, bus.rf_data_o);
                end
            end
        end
        idle(4);
        vectors++;
        if (rx_data.size() != 4) begin
            miscompares++; $display("FAIL cos_count: got %0d want 4", rx_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (int'(rx_data[i]) !== exp_d[i] || rx_last[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cos_out%0d: got %0d/last=%b want %0d/last=0",
                             i, rx_data[i], rx_last[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_sin();
        int exp_d[4] = '{0, -100, 0, 99};
        rx_data.delete(); rx_last.delete();
        for (int i = 0; i < 4; i++) send(0, 100, 1'b0, 1'b0);
        idle(4);
        vectors++;
        if (rx_data.size() != 4) begin
            miscompares++; $display("FAIL sin_count: got %0d want 4", rx_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (int'(rx_data[i]) !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL sin_out%0d: got %0d want %0d", i, rx_data[i], exp_d[i]);
                end
            end
        end
    endtask

    // Line end on the third sample: phases 0,1,2 | 0,1,2,3,0
    task automatic test_last();
        int   exp_d[8] = '{99, 0, -100, 99, 0, -100, 0, 99};
        logic exp_l[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        rx_data.delete(); rx_last.delete();
        for (int i = 0; i < 8; i++) send(100, 0, (i == 2), 1'b0);
        idle(4);
        vectors++;
        if (rx_data.size() != 8) begin
            miscompares++; $display("FAIL last_count: got %0d want 8", rx_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (int'(rx_data[i]) !== exp_d[i] || rx_last[i] !== exp_l[i]) begin
                    miscompares++;
                    $display("FAIL last_out%0d: got %0d/last=%b want %0d/last=%b",
                             i, rx_data[i], rx_last[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    // I=10+i, Q=50+i at phase i%4: a-1, -b, -a, b-1
    task automatic test_stall();
        int exp_d[8] = '{9, -51, -12, 52, 13, -55, -16, 56};
        rx_data.delete(); rx_last.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send(10 + i, 50 + i, (i == 7), (i == 0));
            end
            begin
                int                ready_hi;
                logic signed [9:0] held;
                logic              still_valid;
                ready_hi    = 0;
                still_valid = 1'b1;
                repeat (3) begin
                    @(posedge clk_i);
                    #1;
                end
                bus.rf_ready_i = 1'b0;
                held = bus.rf_data_o;
                repeat (5) begin
                    @(negedge clk_i);
                    if (bus.iq_ready_o) ready_hi++;
                    if (!bus.rf_valid_o) still_valid = 1'b0;
                    @(posedge clk_i);
                    #1;
                end
                vectors++;
                if (ready_hi != 0) begin
                    miscompares++; $display("FAIL stall_ready: ready high %0d cycles want 0", ready_hi);
                end
                vectors++;
                if (bus.rf_data_o !== held || !still_valid) begin
                    miscompares++;
                    $display("FAIL stall_hold: data %0d valid_kept=%b want %0d valid_kept=1",
                             bus.rf_data_o, still_valid, held);
                end
                bus.rf_ready_i = 1'b1;
            end
        join
        idle(5);
        vectors++;
        if (rx_data.size() != 8) begin
            miscompares++; $display("FAIL stall_count: got %0d want 8", rx_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (int'(rx_data[i]) !== exp_d[i] || rx_last[i] !== (i == 7)) begin
                    miscompares++;
                    $display("FAIL stall_out%0d: got %0d/last=%b want %0d/last=%b",
                             i, rx_data[i], rx_last[i], exp_d[i], (i == 7));
                end
            end
        end
    endtask

    // Sync at phase 2 forces phase 0; the following pair lands on phase 1
    task automatic test_sync();
        int exp_d[4] = '{0, 0, 99, -100};
        rx_data.delete(); rx_last.delete();
        send(0, 0, 1'b0, 1'b0);
        send(0, 0, 1'b0, 1'b0);
        send(100, 0, 1'b0, 1'b1);
        send(0, 100, 1'b0, 1'b0);
        idle(4);
        vectors++;
        if (rx_data.size() != 4) begin
            miscompares++; $display("FAIL sync_count: got %0d want 4", rx_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (int'(rx_data[i]) !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL sync_out%0d: got %0d want %0d", i, rx_data[i], exp_d[i]);
                end
            end
        end
`ifdef REMOD_SATURATE_EN
        vectors++;
        if (sat_flag_o !== 1'b0) begin
            miscompares++; $display("FAIL sync_sat_flag: got %b want 0", sat_flag_o);
        end
`endif
    endtask

    // Phase is 2 here: -512 * MIN gives +512, out of range
    task automatic test_sat();
        int exp_v;
`ifdef REMOD_SATURATE_EN
        exp_v = 511;
`else
        exp_v = -512;
`endif
        rx_data.delete(); rx_last.delete();
        send(-512, 0, 1'b0, 1'b0);
        idle(4);
        vectors++;
        if (rx_data.size() != 1) begin
            miscompares++; $display("FAIL sat_count: got %0d want 1", rx_data.size());
        end else begin
            vectors++;
            if (int'(rx_data[0]) !== exp_v) begin
                miscompares++; $display("FAIL sat_out: got %0d want %0d", rx_data[0], exp_v);
            end
        end
`ifdef REMOD_SATURATE_EN
        vectors++;
        if (sat_flag_o !== 1'b1) begin
            miscompares++; $display("FAIL sat_flag: got %b want 1", sat_flag_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        rx_data.delete(); rx_last.delete();
        bus.rf_ready_i = 1'b0;
        send(100, 0, 1'b0, 1'b0);
        send(0, 100, 1'b0, 1'b0);
        bus.iq_valid_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        vectors++;
        if (bus.rf_valid_o !== 1'b0 || bus.iq_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_state: valid=%b ready=%b want valid=0 ready=1",
                     bus.rf_valid_o, bus.iq_ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus.rf_ready_i = 1'b1;
        idle(4);
        vectors++;
        if (rx_data.size() != 0) begin
            miscompares++; $display("FAIL midreset_flush: got %0d outputs want 0", rx_data.size());
        end
        send(100, 0, 1'b1, 1'b0);
        idle(4);
        vectors++;
        if (rx_data.size() != 1 || int'(rx_data[0]) !== 99 || rx_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_phase: count=%0d first=%0d want count=1 first=99 last=1",
                     rx_data.size(), (rx_data.size() > 0) ? int'(rx_data[0]) : 0);
        end
    endtask

    initial begin
        test_reset();
        test_cos();
        test_sin();
        test_last();
        test_stall();
        test_sync();
        test_sat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
